// File: rtl/div_4.sv
// div_4: synchronous clock divider.
// Produces a registered clk_out at 1/DIV_RATIO of clk. The output is high for
// the last H = floor(DIV_RATIO/2) counts of every period, so even ratios give
// a 50% duty cycle and odd ratios are low one cycle longer than they are high.
// clk_out comes straight from a flop, so it is glitch-free and changes only
// on rising edges of clk.
//
// Note: the reset port is named rst_n but is ACTIVE-HIGH and synchronous.
// A 1 on rst_n at a rising edge of clk clears the divider.
module div_4 #(
    parameter int DIV_RATIO = 4,
    parameter int CNT_W     = (DIV_RATIO > 1) ? $clog2(DIV_RATIO) : 1
) (
    input  logic clk,
    input  logic rst_n,
    output logic clk_out
);

    // Ratios below 2 cannot produce a toggling output; reject them at elaboration.
    if (DIV_RATIO < 2) begin : g_bad_ratio
        $error("div_4: DIV_RATIO must be >= 2 (got %0d)", DIV_RATIO);
    end

    // H is the number of high cycles per period.
    localparam int HALF = DIV_RATIO / 2;

    // The last count value before the wrap.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV_RATIO - 1);

    // clk_out goes high once the count reaches this value.
    localparam logic [CNT_W-1:0] HIGH_FROM = CNT_W'(DIV_RATIO - HALF);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             out_next;

    // Work out the next count value (wrapping at DIV_RATIO-1) and the output
    // level that goes with it. Deciding the output from the next count keeps
    // clk_out in step with cnt in the same register stage.
    always_comb begin
        cnt_next = cnt + CNT_W'(1);
        out_next = 1'b0;
        if (cnt == LAST_CNT) begin
            cnt_next = '0;
        end
        out_next = (cnt_next >= HIGH_FROM);
    end

    // Counter and output registers. Reset takes priority over counting.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            cnt     <= '0;
            clk_out <= 1'b0;
        end else begin
            cnt     <= cnt_next;
            clk_out <= out_next;
        end
    end

endmodule

// File: tb/tb_div_4.sv
// tb_div_4: directed bench for div_4.
// Three dividers (ratios 4, 5 and 2) share one clock. Each has its own reset.
// For every step, the bench:
//   - predicts each clk_out from a count of edges since that divider's reset,
//   - pushes the prediction onto a queue before the clock edge,
//   - pops it and compares it with the outputs shortly after the edge.
// The bench also counts run lengths and rising edges, and checks those counts
// against closed-form values.
module tb_div_4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst4 = 1'b1;
    logic rst5 = 1'b1;
    logic rst2 = 1'b1;
    logic out4;
    logic out5;
    logic out2;

    div_4 #(.DIV_RATIO(4)) u4 (.clk(clk), .rst_n(rst4), .clk_out(out4));
    div_4 #(.DIV_RATIO(5)) u5 (.clk(clk), .rst_n(rst5), .clk_out(out5));
    div_4 #(.DIV_RATIO(2)) u2 (.clk(clk), .rst_n(rst2), .clk_out(out2));

    // ---------------- scoreboard ----------------
    logic [2:0] exp_q[$];   // {out2, out5, out4}
    int checks   = 0;
    int failures = 0;

    // Edges seen since the last reset edge, per divider.
    int k4 = 0;
    int k5 = 0;
    int k2 = 0;

    // Run-length / edge statistics
    int rises4 = 0;
    int rises5 = 0;
    int rises2 = 0;
    int high5  = 0;
    logic p4 = 1'b0;
    logic p5 = 1'b0;
    logic p2 = 1'b0;

    // Reference: after k edges out of reset, the output is high when
    // (k mod R) >= R - floor(R/2).
    function automatic logic model(input int k, input int r);
        return ((k % r) >= (r - r / 2));
    endfunction

    // Rising edges of clk_out within edges 1..n after release.
    function automatic int rises_expected(input int n, input int r);
        return (n + r / 2) / r;
    endfunction

    task automatic check_bit(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Drive the resets for one cycle, queue the prediction, then compare it
    // after the edge.
    task automatic step(input string tag, input logic r4, input logic r5, input logic r2);
        logic [2:0] e;
        logic [2:0] got;

        rst4 = r4;
        rst5 = r5;
        rst2 = r2;

        k4 = r4 ? 0 : k4 + 1;
        k5 = r5 ? 0 : k5 + 1;
        k2 = r2 ? 0 : k2 + 1;

        exp_q.push_back({model(k2, 2), model(k5, 5), model(k4, 4)});

        @(posedge clk);
        #1;

        got = {out2, out5, out4};
        e   = exp_q.pop_front();

        checks++;
        assert (got === e)
        else begin
            failures++;
            $error("FAIL %s t=%0t observed{o2,o5,o4}=%b expected=%b", tag, $time, got, e);
        end

        if (out4 && !p4) rises4++;
        if (out5 && !p5) rises5++;
        if (out2 && !p2) rises2++;
        if (out5) high5++;

        p4 = out4;
        p5 = out5;
        p2 = out2;
    endtask

    task automatic clear_stats();
        rises4 = 0;
        rises5 = 0;
        rises2 = 0;
        high5  = 0;
        p4 = 1'b0;
        p5 = 1'b0;
        p2 = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        // Reset hold: 5 edges with reset asserted, counters must stay at zero.
        for (int i = 0; i < 5; i++) begin
            step("reset_hold", 1'b1, 1'b1, 1'b1);
            check_int("cnt4_in_reset", int'(u4.cnt), 0);
            check_int("cnt5_in_reset", int'(u5.cnt), 0);
            check_int("cnt2_in_reset", int'(u2.cnt), 0);
        end

        // Release and run 100 cycles. Ratio 5 completes 20 full periods.
        clear_stats();
        step("first_edge", 1'b0, 1'b0, 1'b0);
        check_bit("ratio4_low_after_1_edge", out4, 1'b0);
        step("second_edge", 1'b0, 1'b0, 1'b0);
        check_bit("ratio4_first_rise_at_2", out4, 1'b1);
        for (int i = 2; i < 100; i++) begin
            step("run100", 1'b0, 1'b0, 1'b0);
        end
        check_int("ratio5_high_cycles_20_periods", high5, 40);
        check_int("ratio4_rises_100", rises4, rises_expected(100, 4));
        check_int("ratio2_rises_100", rises2, rises_expected(100, 2));

        // Mid-run reset on ratio 4 while its output is high.
        step("pre_mid", 1'b0, 1'b0, 1'b0);
        step("pre_mid", 1'b0, 1'b0, 1'b0);
        check_bit("ratio4_high_before_mid_reset", out4, 1'b1);
        step("mid_reset", 1'b1, 1'b0, 1'b0);
        check_bit("ratio4_low_after_mid_reset", out4, 1'b0);
        check_int("cnt4_after_mid_reset", int'(u4.cnt), 0);
        for (int i = 0; i < 8; i++) begin
            step("restart_0011", 1'b0, 1'b0, 1'b0);
        end

        // Long run: common reset, then 1000 cycles (10 us).
        step("long_reset", 1'b1, 1'b1, 1'b1);
        clear_stats();
        for (int i = 0; i < 1000; i++) begin
            step("long_run", 1'b0, 1'b0, 1'b0);
        end
        check_int("ratio4_rises_1000", rises4, rises_expected(1000, 4));
        check_int("ratio5_rises_1000", rises5, rises_expected(1000, 5));
        check_int("ratio2_rises_1000", rises2, rises_expected(1000, 2));
        check_int("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
